// File: rtl/ifmaps_preload_ctrl.sv
// Ifmap tile sequencer: streams one tile into the preload buffer and hands only fully
// written vectors to the MAC array. The block keeps its own occupancy because the buffer
// counts a vector as present from its first word.
module ifmaps_preload_ctrl #(
   parameter int C_S_AXIS_TDATA_WIDTH = 32,
   parameter int FIFO_DEPTH           = 4,
   parameter int PIX_W                = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [8:0]       cfg_input_channel,
   input  logic [PIX_W-1:0] cfg_pixel_num,
   output logic             busy,
   output logic             done,
   output logic             err_cfg,
   output logic             err_tlast,
   input  logic             s_axis_tvalid,
   input  logic             s_axis_tlast,
   output logic             s_axis_tready,
   output logic             load_ifmaps_preload,
   output logic [8:0]       input_channel,
   input  logic             fifo_full,
   input  logic             fifo_empty,
   input  logic             mac_ready,
   output logic             mac_valid,
   output logic             MAC_read
);

   localparam int OCC_W = $clog2(FIFO_DEPTH + 1);

   typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

   state_t           state, state_next;
   logic [8:0]       word_cnt;
   logic [PIX_W-1:0] pix, wr_vec, rd_vec;
   logic [OCC_W-1:0] started, started_next, ready_cnt, ready_next;
   logic             cfg_bad, start_ok, last_word, vec_open, vec_done;

   // Buffer flags are observed by the environment only; the tile width is context only.
   logic unused_ok;
   assign unused_ok = &{1'b0, fifo_full, fifo_empty, (C_S_AXIS_TDATA_WIDTH > 0)};

   assign cfg_bad   = (cfg_input_channel == 9'd0) || (cfg_pixel_num == '0);
   assign start_ok  = start && (state == IDLE);
   assign last_word = (word_cnt == input_channel - 9'd1);

   // Cap in-flight vectors one below the buffer depth; a vector already open may finish.
   assign s_axis_tready = (state == LOAD)
                        && ((word_cnt != 9'd0) || (started < OCC_W'(FIFO_DEPTH - 1)))
                        && (wr_vec < pix);
   assign load_ifmaps_preload = s_axis_tvalid && s_axis_tready;
   assign MAC_read = mac_valid && mac_ready && ((state == LOAD) || (state == DRAIN));
   assign busy     = (state != IDLE);
   assign done     = (state == DONE);

   assign vec_open = load_ifmaps_preload && (word_cnt == 9'd0);
   assign vec_done = load_ifmaps_preload && last_word;

   always_comb begin
      state_next = state;
      case (state)
         IDLE:  if (start) state_next = cfg_bad ? DONE : LOAD;
         LOAD:  if (wr_vec == pix) state_next = DRAIN;
         DRAIN: if (rd_vec == pix) state_next = DONE;
         DONE:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      started_next = started;
      ready_next   = ready_cnt;
      case ({vec_open, MAC_read})
         2'b10:   started_next = started + OCC_W'(1);
         2'b01:   started_next = started - OCC_W'(1);
         default: started_next = started;
      endcase
      case ({vec_done, MAC_read})
         2'b10:   ready_next = ready_cnt + OCC_W'(1);
         2'b01:   ready_next = ready_cnt - OCC_W'(1);
         default: ready_next = ready_cnt;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         input_channel <= 9'd0;
         pix           <= '0;
         word_cnt      <= 9'd0;
         wr_vec        <= '0;
         rd_vec        <= '0;
         started       <= '0;
         ready_cnt     <= '0;
         mac_valid     <= 1'b0;
         err_cfg       <= 1'b0;
         err_tlast     <= 1'b0;
      end else begin
         state <= state_next;
         if (start_ok) begin
            input_channel <= cfg_input_channel;
            pix           <= cfg_pixel_num;
            word_cnt      <= 9'd0;
            wr_vec        <= '0;
            rd_vec        <= '0;
            started       <= '0;
            ready_cnt     <= '0;
            mac_valid     <= 1'b0;
            err_cfg       <= cfg_bad;
            err_tlast     <= 1'b0;
         end else begin
            if (load_ifmaps_preload) begin
               word_cnt <= last_word ? 9'd0 : word_cnt + 9'd1;
               if (last_word) wr_vec <= wr_vec + PIX_W'(1);
               // Misplaced tlast is flagged but framing still follows word_cnt.
               if (s_axis_tlast != last_word) err_tlast <= 1'b1;
            end
            if (MAC_read) rd_vec <= rd_vec + PIX_W'(1);
            started   <= started_next;
            ready_cnt <= ready_next;
            mac_valid <= (ready_next != '0);
         end
      end
   end

endmodule

// File: tb/tb_ifmaps_preload_ctrl.sv
// Randomized bench for ifmaps_preload_ctrl: a count-based tile model predicts every output
// each cycle, an external buffer model drives the fifo flags, directed tiles pin literals.
module tb_ifmaps_preload_ctrl;
   localparam int D  = 4;
   localparam int PW = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [8:0]    cfg_ic = 9'd0;
   logic [PW-1:0] cfg_pix = '0;
   logic          busy, done, err_cfg, err_tlast;
   logic          s_axis_tvalid = 1'b0, s_axis_tlast = 1'b0, s_axis_tready;
   logic          load_ifmaps_preload;
   logic [8:0]    input_channel;
   logic          fifo_full = 1'b0, fifo_empty = 1'b1;
   logic          mac_ready = 1'b0, mac_valid, MAC_read;

   ifmaps_preload_ctrl #(.C_S_AXIS_TDATA_WIDTH(32), .FIFO_DEPTH(D), .PIX_W(PW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .cfg_input_channel(cfg_ic), .cfg_pixel_num(cfg_pix),
      .busy(busy), .done(done), .err_cfg(err_cfg), .err_tlast(err_tlast),
      .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
      .load_ifmaps_preload(load_ifmaps_preload), .input_channel(input_channel),
      .fifo_full(fifo_full), .fifo_empty(fifo_empty),
      .mac_ready(mac_ready), .mac_valid(mac_valid), .MAC_read(MAC_read)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Tile model: phase 0 idle, 1 loading, 2 draining, 3 done; everything else from word/read counts.
   int m_phase = 0, m_ic = 0, m_pix = 0, m_words = 0, m_reads = 0, m_icout = 0;
   int m_err_cfg = 0, m_err_tlast = 0, m_mv = 0;
   int wc, wv, st, rdy, rd_old, e_tready, e_load, e_read;
   int buf_cnt = 0, buf_wc = 0;

   // Stimulus controls (0 off, 1 always, 2 random) and tlast corruption indices.
   int tv_mode = 0, mr_mode = 0, bad_a = -1, bad_b = -1, rand_start = 0;

   // Event log
   int cyc = 0, ev_loads = 0, ev_reads = 0, ev_done = 0, ev_mv_rise = 0;
   int c_load4 = -1, c_mv_first = -1, mv_prev = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      cyc++;
      if (!rst_n) begin
         chk("rst_busy", busy, 0);           chk("rst_done", done, 0);
         chk("rst_tready", s_axis_tready, 0); chk("rst_load", load_ifmaps_preload, 0);
         chk("rst_mac_valid", mac_valid, 0); chk("rst_mac_read", MAC_read, 0);
         chk("rst_ic", input_channel, 0);    chk("rst_err_cfg", err_cfg, 0);
         chk("rst_err_tlast", err_tlast, 0);
         m_phase = 0; m_ic = 0; m_pix = 0; m_words = 0; m_reads = 0; m_icout = 0;
         m_err_cfg = 0; m_err_tlast = 0; m_mv = 0; mv_prev = 0;
         buf_cnt = 0; buf_wc = 0; fifo_full = 1'b0; fifo_empty = 1'b1;
      end else begin
         if (m_ic != 0) begin
            wc = m_words % m_ic;
            wv = m_words / m_ic;
            st = (m_words + m_ic - 1) / m_ic - m_reads;
         end else begin
            wc = 0; wv = 0; st = 0;
         end
         rdy      = wv - m_reads;
         e_tready = int'(m_phase == 1 && (wc != 0 || st < D - 1) && wv < m_pix);
         e_load   = int'(e_tready != 0 && s_axis_tvalid);
         e_read   = int'(m_mv != 0 && mac_ready && (m_phase == 1 || m_phase == 2));

         chk("busy", busy, m_phase != 0);
         chk("done", done, m_phase == 3);
         chk("tready", s_axis_tready, e_tready);
         chk("load", load_ifmaps_preload, e_load);
         chk("mac_valid", mac_valid, m_mv);
         chk("mac_read", MAC_read, e_read);
         chk("input_channel", input_channel, m_icout);
         chk("err_cfg", err_cfg, m_err_cfg);
         chk("err_tlast", err_tlast, m_err_tlast);
         chk("fifo_full_mon", fifo_full, 0);
         chk("fifo_empty_mon", fifo_empty && (rdy != 0), 0);

         if (load_ifmaps_preload) begin
            ev_loads++;
            if (ev_loads == 4) c_load4 = cyc;
         end
         if (MAC_read) ev_reads++;
         if (done) ev_done++;
         if (mac_valid && mv_prev == 0) begin
            ev_mv_rise++;
            if (ev_mv_rise == 1) c_mv_first = cyc;
         end
         mv_prev = int'(mac_valid);

         // External buffer: a vector occupies a slot from its first word until popped.
         if (load_ifmaps_preload) begin
            if (buf_wc == 0) buf_cnt++;
            buf_wc = (buf_wc + 1 >= int'(input_channel)) ? 0 : buf_wc + 1;
         end
         if (MAC_read) buf_cnt--;
         fifo_full  = (buf_cnt >= D);
         fifo_empty = (buf_cnt == 0);

         case (m_phase)
            0: if (start) begin
                  m_ic = int'(cfg_ic); m_pix = int'(cfg_pix); m_icout = int'(cfg_ic);
                  m_words = 0; m_reads = 0; m_mv = 0; m_err_tlast = 0;
                  m_err_cfg = int'(cfg_ic == 0 || cfg_pix == 0);
                  m_phase = (m_err_cfg != 0) ? 3 : 1;
               end
            1, 2: begin
               rd_old = m_reads;
               if (e_load != 0) begin
                  if (s_axis_tlast != (wc == m_ic - 1)) m_err_tlast = 1;
                  m_words++;
               end
               if (e_read != 0) m_reads++;
               m_mv = int'((m_words / m_ic - m_reads) != 0);
               if (m_phase == 1 && wv == m_pix) m_phase = 2;
               else if (m_phase == 2 && rd_old == m_pix) m_phase = 3;
            end
            default: m_phase = 0;
         endcase
      end
   end

   // Input driver: changes inputs 1 time unit after each rising edge.
   initial begin
      int p;
      logic tl;
      forever begin
         @(posedge clk);
         #1;
         s_axis_tvalid = (tv_mode == 1) ? 1'b1 : (tv_mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b0;
         mac_ready     = (mr_mode == 1) ? 1'b1 : (mr_mode == 2) ? ($urandom_range(0, 2) != 0) : 1'b0;
         tl = 1'b0;
         if (m_ic != 0) begin
            p  = m_words % m_ic;
            tl = (p == m_ic - 1);
            if (m_words == bad_a || m_words == bad_b) tl = ~tl;
         end
         s_axis_tlast = tl;
         if (rand_start != 0) begin
            if (m_phase == 1 || m_phase == 2) begin
               start   = ($urandom_range(0, 7) == 0);
               cfg_ic  = 9'($urandom);
               cfg_pix = PW'($urandom);
            end else begin
               start = 1'b0;
            end
         end
      end
   end

   task automatic clear_ev();
      ev_loads = 0; ev_reads = 0; ev_done = 0; ev_mv_rise = 0; c_load4 = -1; c_mv_first = -1;
   endtask

   task automatic start_tile(input int ic, input int pix);
      @(posedge clk);
      #1;
      cfg_ic  = 9'(ic);
      cfg_pix = PW'(pix);
      start   = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input string name, input int limit);
      int n = 0;
      while (ev_done == 0 && n < limit) begin
         @(posedge clk);
         #2;
         n++;
      end
      n_checks++;
      if (ev_done == 0) begin
         n_errors++;
         $display("FAIL %s_timeout: got no done within %0d cycles, required done", name, limit);
      end
      repeat (2) @(posedge clk);
      #2;
   endtask

   initial begin
      #1_000_000;
      n_errors++;
      $display("FAIL watchdog: got no end of test, required completion");
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      int n;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (2) @(posedge clk);

      // 1: basic two-vector tile
      clear_ev(); tv_mode = 1; mr_mode = 1;
      start_tile(4, 2);
      wait_done("t1", 100);
      chk("t1_loads", ev_loads, 8);        chk("t1_reads", ev_reads, 2);
      chk("t1_done", ev_done, 1);          chk("t1_mv_lat", c_mv_first - c_load4, 1);
      chk("t1_err_tlast", err_tlast, 0);   chk("t1_err_cfg", err_cfg, 0);
      $display("t1 ic=4 pix=2 loads=%0d reads=%0d", ev_loads, ev_reads);

      // 2: MAC stalled, stream must stop at FIFO_DEPTH-1 vectors
      clear_ev(); tv_mode = 1; mr_mode = 0;
      start_tile(2, 6);
      repeat (20) @(posedge clk);
      #2;
      chk("t2_loads_stall", ev_loads, 6);  chk("t2_tready_stall", s_axis_tready, 0);
      chk("t2_fifo_full", fifo_full, 0);
      mr_mode = 1;
      wait_done("t2", 200);
      chk("t2_loads", ev_loads, 12);       chk("t2_reads", ev_reads, 6);
      $display("t2 ic=2 pix=6 loads=%0d reads=%0d", ev_loads, ev_reads);

      // 3: single-word vectors, completion and pop every cycle
      clear_ev(); tv_mode = 1; mr_mode = 1;
      start_tile(1, 4);
      wait_done("t3", 100);
      chk("t3_loads", ev_loads, 4);        chk("t3_reads", ev_reads, 4);
      chk("t3_mv_rises", ev_mv_rise, 1);
      $display("t3 ic=1 pix=4 loads=%0d reads=%0d", ev_loads, ev_reads);

      // 4: tlast early on word 3 and missing on word 4
      clear_ev(); bad_a = 2; bad_b = 3;
      start_tile(4, 1);
      wait_done("t4", 100);
      bad_a = -1; bad_b = -1;
      repeat (3) @(posedge clk);
      #2;
      chk("t4_err_tlast", err_tlast, 1);   chk("t4_loads", ev_loads, 4);
      chk("t4_reads", ev_reads, 1);        chk("t4_done", ev_done, 1);
      $display("t4 ic=4 pix=1 err_tlast=%0d", err_tlast);

      // 5: widest vector, then zero pixel count
      clear_ev();
      start_tile(256, 1);
      wait_done("t5", 600);
      chk("t5_loads", ev_loads, 256);      chk("t5_mv_rises", ev_mv_rise, 1);
      chk("t5_reads", ev_reads, 1);        chk("t5_err_tlast", err_tlast, 0);
      clear_ev();
      start_tile(5, 0);
      chk("t5b_done", done, 1);            chk("t5b_err_cfg", err_cfg, 1);
      repeat (3) @(posedge clk);
      #2;
      chk("t5b_loads", ev_loads, 0);       chk("t5b_done_cnt", ev_done, 1);
      $display("t5 ic=256 pix=1 then pix=0 err_cfg=%0d", err_cfg);

      // 6: reset in the middle of loading
      clear_ev();
      start_tile(8, 2);
      n = 0;
      while (ev_loads < 3 && n < 50) begin
         @(posedge clk);
         #2;
         n++;
      end
      chk("t6_loads_before_rst", ev_loads, 3);
      rst_n = 1'b0;
      #1;
      chk("t6_tready", s_axis_tready, 0);  chk("t6_load", load_ifmaps_preload, 0);
      chk("t6_mac_read", MAC_read, 0);     chk("t6_mac_valid", mac_valid, 0);
      chk("t6_busy", busy, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      chk("t6_no_done", ev_done, 0);
      clear_ev();
      start_tile(2, 1);
      wait_done("t6", 100);
      chk("t6_loads", ev_loads, 2);        chk("t6_reads", ev_reads, 1);
      $display("t6 reset mid-tile, restart loads=%0d reads=%0d", ev_loads, ev_reads);

      // Random tiles with random handshakes, ignored starts and occasional bad tlast/cfg
      for (int t = 0; t < 40; t++) begin
         int ic, pix;
         ic  = ($urandom_range(0, 7) == 0) ? $urandom_range(9, 40) : $urandom_range(1, 6);
         pix = $urandom_range(1, 7);
         if ($urandom_range(0, 9) == 0) begin
            if ($urandom_range(0, 1) == 0) ic = 0; else pix = 0;
         end
         bad_a = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 20) : -1;
         clear_ev(); tv_mode = 2; mr_mode = 2;
         start_tile(ic, pix);
         rand_start = 1;
         wait_done("rand", 3000);
         rand_start = 0;
         @(posedge clk);
         #2 start = 1'b0;
         $display("rand tile %0d ic=%0d pix=%0d loads=%0d reads=%0d err_tlast=%0d err_cfg=%0d",
                  t, ic, pix, ev_loads, ev_reads, err_tlast, err_cfg);
      end
      bad_a = -1; tv_mode = 0; mr_mode = 0;
      repeat (3) @(posedge clk);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
